// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer between NUM_REQ byte sources.
// Latency: valid in IDLE -> o_req_ready next cycle -> o_tx_dv the cycle after.
// Backpressure: a requester holds valid/byte until its ready pulse; optional lock via UART_TX_ARBITER_LOCK_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 0,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_byte,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx_dv,
  output logic [7:0]           o_tx_byte,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic [2:0]           o_grant_id,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_GAP} state_t;

  state_t               r_state, w_state_nxt;
  logic [PW-1:0]        r_ptr, w_ptr_nxt;
  logic [GW-1:0]        r_gap_cnt, w_gap_cnt_nxt;
  logic [TW-1:0]        r_to_cnt, w_to_cnt_nxt;
  logic [NUM_REQ-1:0]   r_req_ready, w_req_ready_nxt;
  logic                 r_tx_dv, w_tx_dv_nxt;
  logic [7:0]           r_tx_byte, w_tx_byte_nxt;
  logic [2:0]           r_grant_id, w_grant_id_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic [NUM_REQ-1:0]   w_elig;
  logic                 w_found;
  logic [PW-1:0]        w_sel;
  logic                 w_unused;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] k);
    return (k == PW'(NUM_REQ - 1)) ? '0 : k + 1'b1;
  endfunction

`ifdef UART_TX_ARBITER_LOCK_EN
  logic          r_lock, w_lock_nxt;
  logic [PW-1:0] r_lock_id, w_lock_id_nxt;
  // While a multi-byte message is in flight only its owner is eligible.
  assign w_elig   = r_lock ? (i_req_valid & (NUM_REQ'(1) << r_lock_id)) : i_req_valid;
  assign w_unused = i_tx_active;
`else
  assign w_elig   = i_req_valid;
  assign w_unused = ^{i_tx_active, i_req_last};
`endif

  // First eligible requester at or above the RR pointer, wrapping around.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(r_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && w_elig[PW'(j)]) begin
        w_found = 1'b1;
        w_sel   = PW'(j);
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_to_cnt_nxt    = r_to_cnt;
    w_req_ready_nxt = '0;
    w_tx_dv_nxt     = 1'b0;
    w_tx_byte_nxt   = r_tx_byte;
    w_grant_id_nxt  = r_grant_id;
    w_timeout_nxt   = 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
    w_lock_nxt      = r_lock;
    w_lock_id_nxt   = r_lock_id;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_req_ready_nxt = NUM_REQ'(1) << w_sel;
          w_tx_byte_nxt   = i_req_byte[{w_sel, 3'b000} +: 8];
          w_grant_id_nxt  = 3'(w_sel);
          w_state_nxt     = S_LAUNCH;
`ifdef UART_TX_ARBITER_LOCK_EN
          // Pointer only moves once the owner's message ends.
          if (i_req_last[w_sel]) begin
            w_lock_nxt = 1'b0;
            w_ptr_nxt  = f_next(w_sel);
          end else begin
            w_lock_nxt    = 1'b1;
            w_lock_id_nxt = w_sel;
          end
`else
          w_ptr_nxt = f_next(w_sel);
`endif
        end
      end
      S_LAUNCH: begin
        w_tx_dv_nxt  = 1'b1;
        w_to_cnt_nxt = '0;
        w_state_nxt  = S_BUSY;
      end
      S_BUSY: begin
        // Done takes priority over a simultaneous timeout expiry.
        if (i_tx_done) begin
          w_gap_cnt_nxt = '0;
          w_state_nxt   = (GAP_CLKS > 0) ? S_GAP : S_IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
`ifdef UART_TX_ARBITER_LOCK_EN
          if (r_lock) begin
            w_lock_nxt = 1'b0;
            w_ptr_nxt  = f_next(r_lock_id);
          end
`endif
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
        else                       w_gap_cnt_nxt = r_gap_cnt + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gap_cnt   <= '0;
      r_to_cnt    <= '0;
      r_req_ready <= '0;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_grant_id  <= 3'd0;
      r_timeout   <= 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
      r_lock      <= 1'b0;
      r_lock_id   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_tx_dv     <= w_tx_dv_nxt;
      r_tx_byte   <= w_tx_byte_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_timeout   <= w_timeout_nxt;
`ifdef UART_TX_ARBITER_LOCK_EN
      r_lock      <= w_lock_nxt;
      r_lock_id   <= w_lock_id_nxt;
`endif
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_tx_dv     = r_tx_dv;
  assign o_tx_byte   = r_tx_byte;
  assign o_grant_id  = r_grant_id;
  assign o_timeout   = r_timeout;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance A (GAP 0, timeout 16) and B (GAP 10).
// Outputs are sampled 1 time unit after each rising edge; inputs change at that point.
// Expected grant order and latencies are hand-derived from the arbiter's behaviour.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_byte;
  logic [3:0]  req_last;
  logic        tx_active;
  logic        done_a, done_b;
  logic [3:0]  ready_a, ready_b;
  logic        dv_a, dv_b, busy_a, busy_b, to_a, to_b;
  logic [7:0]  byte_a, byte_b;
  logic [2:0]  gid_a, gid_b;

  int n_vec = 0;
  int n_err = 0;
  bit r2_active;
  int r2_idx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(0), .TIMEOUT_CLKS(16)) u_dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_req_valid(req_valid), .i_req_byte(req_byte),
    .i_req_last(req_last), .o_req_ready(ready_a), .o_tx_dv(dv_a), .o_tx_byte(byte_a),
    .i_tx_active(tx_active), .i_tx_done(done_a), .o_grant_id(gid_a), .o_busy(busy_a),
    .o_timeout(to_a));

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(10), .TIMEOUT_CLKS(16)) u_dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_req_valid(req_valid), .i_req_byte(req_byte),
    .i_req_last(req_last), .o_req_ready(ready_b), .o_tx_dv(dv_b), .o_tx_byte(byte_b),
    .i_tx_active(tx_active), .i_tx_done(done_b), .o_grant_id(gid_b), .o_busy(busy_b),
    .o_timeout(to_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    done_a    = 1'b0;
    done_b    = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
    tick();
  endtask

  // Wait for a grant on A, check it, update requester-2 model, then finish the byte.
  task automatic serve(input logic [2:0] id, input logic [7:0] b);
    int n;
    n = 0;
    while (ready_a == 4'b0000 && n < 30) begin
      tick();
      n++;
    end
    check("serve_ready", 32'(ready_a), 32'(4'b0001 << id));
    check("serve_gid", 32'(gid_a), 32'(id));
    check("serve_byte", 32'(byte_a), 32'(b));
    if (r2_active && ready_a[2]) begin
      r2_idx++;
      if (r2_idx == 3) begin
        req_valid[2] = 1'b0;
        r2_active    = 1'b0;
      end else begin
        req_byte[23:16] = 8'hA0 + 8'(r2_idx);
        req_last[2]     = (r2_idx == 2);
      end
    end
    tick();
    check("serve_dv", 32'(dv_a), 32'd1);
    tick();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nb;
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_byte  = 32'h0;
    req_last  = 4'b0000;
    tx_active = 1'b0;
    done_a    = 1'b0;
    done_b    = 1'b0;
    r2_active = 1'b0;
    r2_idx    = 0;
    tick();
    tick();
    // Reset values
    check("rst_ready", 32'(ready_a), 32'd0);
    check("rst_dv", 32'(dv_a), 32'd0);
    check("rst_byte", 32'(byte_a), 32'd0);
    check("rst_gid", 32'(gid_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_timeout", 32'(to_a), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single requester, latency chain
    req_byte[15:8] = 8'h41;
    req_valid      = 4'b0010;
    tick();
    check("single_ready", 32'(ready_a), 32'(4'b0010));
    check("single_gid", 32'(gid_a), 32'd1);
    check("single_byte", 32'(byte_a), 32'h41);
    check("single_dv_early", 32'(dv_a), 32'd0);
    check("single_busy", 32'(busy_a), 32'd1);
    req_valid = 4'b0000;
    tick();
    check("single_ready_pulse", 32'(ready_a), 32'd0);
    check("single_dv", 32'(dv_a), 32'd1);
    check("single_byte_launch", 32'(byte_a), 32'h41);
    tick();
    check("single_dv_once", 32'(dv_a), 32'd0);
    check("single_busy_wait", 32'(busy_a), 32'd1);
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    check("single_busy_fall", 32'(busy_a), 32'd0);
    // Done pulse while idle is ignored
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    tick();
    check("stray_done_busy", 32'(busy_a), 32'd0);
    check("stray_done_ready", 32'(ready_a), 32'd0);

    // Round-robin fairness, all continuously valid
    do_reset();
    req_byte  = 32'h33323130;
    req_valid = 4'b1111;
    serve(3'd0, 8'h30);
    serve(3'd1, 8'h31);
    serve(3'd2, 8'h32);
    serve(3'd3, 8'h33);
    serve(3'd0, 8'h30);
    req_valid = 4'b0000;

    // Timeout: transmitter never completes
    do_reset();
    req_byte  = 32'hD30000D0;
    req_valid = 4'b1001;
    n = 0;
    while (ready_a == 4'b0000 && n < 10) begin
      tick();
      n++;
    end
    check("to_grant0", 32'(ready_a), 32'(4'b0001));
    req_valid[0] = 1'b0;
    tick();
    check("to_dv", 32'(dv_a), 32'd1);
    n = 0;
    while (to_a == 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check("to_latency", 32'(n), 32'd16);
    check("to_idle", 32'(busy_a), 32'd0);
    tick();
    check("to_pulse", 32'(to_a), 32'd0);
    check("to_next_ready", 32'(ready_a), 32'(4'b1000));
    check("to_next_byte", 32'(byte_a), 32'hD3);
    req_valid = 4'b0000;

    // Gap on instance B: 10 gap cycles plus one arbitration cycle
    do_reset();
    req_byte  = 32'h0000B1B0;
    req_valid = 4'b0011;
    n = 0;
    while (ready_b == 4'b0000 && n < 10) begin
      tick();
      n++;
    end
    check("gap_first_ready", 32'(ready_b), 32'(4'b0001));
    tick();
    tick();
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    n  = 0;
    nb = 0;
    while (ready_b == 4'b0000 && n < 40) begin
      if (busy_b) nb++;
      tick();
      n++;
    end
    check("gap_busy_cycles", 32'(nb), 32'd10);
    check("gap_to_ready", 32'(n), 32'd11);
    check("gap_next_gid", 32'(gid_b), 32'd1);
    req_valid = 4'b0000;

    // Asynchronous reset in BUSY
    do_reset();
    req_byte  = 32'hE300E1E0;
    req_valid = 4'b0010;
    n = 0;
    while (ready_a == 4'b0000 && n < 10) begin
      tick();
      n++;
    end
    check("arst_pre_gid", 32'(gid_a), 32'd1);
    req_valid = 4'b1001;
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_byte", 32'(byte_a), 32'd0);
    check("arst_gid", 32'(gid_a), 32'd0);
    check("arst_dv", 32'(dv_a), 32'd0);
    check("arst_ready", 32'(ready_a), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("arst_post_ready", 32'(ready_a), 32'(4'b0001));
    check("arst_post_byte", 32'(byte_a), 32'hE0);
    req_valid = 4'b0000;

    // Message lock: req2 sends three bytes while req0 stays valid
    do_reset();
    req_byte        = 32'h0;
    req_byte[23:16] = 8'hA0;
    req_last        = 4'b0000;
    r2_idx          = 0;
    r2_active       = 1'b1;
    req_valid       = 4'b0100;
    serve(3'd2, 8'hA0);
    req_byte[7:0] = 8'h55;
    req_valid[0]  = 1'b1;
`ifdef UART_TX_ARBITER_LOCK_EN
    serve(3'd2, 8'hA1);
    serve(3'd2, 8'hA2);
    serve(3'd0, 8'h55);
`else
    serve(3'd0, 8'h55);
    serve(3'd2, 8'hA1);
    serve(3'd0, 8'h55);
`endif
    req_valid = 4'b0000;
    r2_active = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Latches the granted byte and issues a one-cycle data-valid pulse to the transmitter.
- Waits for the transmitter's done pulse, then enforces an optional inter-byte idle gap.
- Sits between the application-side message sources (loopback echo, status reporter, etc.) and the UART TX serializer.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- GAP_CLKS, 0, idle clocks inserted after each tx_done before the next arbitration; 0 means no gap.
- TIMEOUT_CLKS, 4096, maximum clocks to wait for i_tx_done after launch before aborting.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  reset, asynchronous, active-low.
- i_req_valid  input  NUM_REQ  per-requester byte-valid; bit k belongs to requester k.
- i_req_byte  input  8*NUM_REQ  flattened bytes; requester k uses bits [8k+7:8k].
- i_req_last  input  NUM_REQ  end-of-message flag per requester (used only with the optional feature).
- o_req_ready  output  NUM_REQ  one-hot, one-cycle pulse: byte of requester k accepted this cycle.
- o_tx_dv  output  1  one-cycle launch pulse to the transmitter.
- o_tx_byte  output  8  byte to the transmitter; held stable from launch until done.
- i_tx_active  input  1  transmitter busy flag.
- i_tx_done  input  1  transmitter one-cycle completion pulse.
- o_grant_id  output  3  index of the current or last granted requester.
- o_busy  output  1  high in any state except IDLE.
- o_timeout  output  1  one-cycle pulse when TIMEOUT_CLKS expires.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; RR pointer=0; gap and timeout counters=0.
  - o_req_ready=0, o_tx_dv=0, o_tx_byte=8'h00, o_grant_id=0, o_busy=0, o_timeout=0.
- States: IDLE, LAUNCH, BUSY, GAP.
- IDLE:
  - If any i_req_valid bit is set, grant the first set bit searching from the RR pointer upward, with wrap.
  - In the same cycle: o_req_ready[k]=1, latch the byte into o_tx_byte, o_grant_id=k, pointer=(k+1) mod NUM_REQ, go to LAUNCH.
  - No valid bits: stay in IDLE.
- LAUNCH: o_tx_dv=1 for exactly this one cycle; clear the timeout counter; go to BUSY.
- BUSY:
  - Increment the timeout counter each cycle.
  - On i_tx_done: go to GAP if GAP_CLKS>0, else IDLE.
  - If the counter reaches TIMEOUT_CLKS-1 without i_tx_done: pulse o_timeout and go to IDLE.
  - i_tx_active is monitoring only and does not gate transitions.
- GAP: count GAP_CLKS cycles, then go to IDLE.
- Latency:
  - Valid seen in IDLE → o_req_ready the same clock edge (registered, visible next cycle).
  - o_tx_dv follows one cycle after o_req_ready.
  - Earliest next grant: the cycle after i_tx_done when GAP_CLKS=0.
- Handshake rules:
  - A requester holds its valid and byte until it sees its ready pulse; the arbiter never re-samples after grant.
  - Valid deasserted before grant means no transfer; this is legal.
  - At most one ready bit is asserted per cycle.
- Simultaneous i_tx_done and timeout expiry: done wins, no o_timeout.
- i_tx_done seen outside BUSY is ignored.
- Reset asserted mid-BUSY: immediate return to reset values. The already-launched byte on the transmitter is not tracked.
- Counter widths: sized by $clog2 of the parameter, minimum 1 bit; no wrap inside a state.

Optional Feature:
- Macro: UART_TX_ARBITER_LOCK_EN.
- With the macro:
  - Granting requester k while i_req_last[k]=0 sets a lock. While locked, IDLE considers only requester k and other valid bits are ignored.
  - The lock clears when a byte from k is accepted with i_req_last[k]=1, or on o_timeout.
  - The RR pointer advances only when the lock clears.
- Without the macro: i_req_last is ignored, and every byte is arbitrated independently.

Test Plan:
- Single requester: req1 valid with byte 8'h41, GAP_CLKS=0 → o_req_ready=4'b0010 for 1 cycle, o_tx_dv 1 cycle later with o_tx_byte=8'h41, o_grant_id=1, o_busy falls the cycle after the i_tx_done model pulse.
- Round-robin fairness: all 4 valid continuously with bytes 8'h30..8'h33 → grant order 0,1,2,3,0; no requester granted twice before all others are served.
- Gap: GAP_CLKS=10, two requesters valid → exactly 10 idle cycles between i_tx_done and the next o_req_ready pulse.
- Timeout: TIMEOUT_CLKS=16, TX model never pulses done → o_timeout pulses 16 cycles after o_tx_dv, state returns to IDLE, next pending request is granted.
- Reset mid-BUSY: drop i_rst during BUSY → all outputs 0 asynchronously; after release, a pending req0 is granted first.
- Lock feature enabled: req2 sends 3 bytes with last=0,0,1 while req0 is continuously valid → req2's three bytes go out consecutively, then req0 is granted; with the macro off, grants alternate 2,0,2,0.
